// File: rtl/jt6295_seq.sv
// jt6295_seq: command sequencer in front of the jt6295 ADPCM core.
// Queues play/stop requests in a small FIFO and serialises each one into
// the core's byte-wide wrn/din write protocol (play = 2 bytes, stop = 1).
// Before a play is written, the target channel's busy flag is checked;
// the request either waits for it (bounded by TOUT cen pulses) or is dropped.
//
// Ports:
//   clk, rst_n  system clock, asynchronous active-low reset
//   cen         clock enable shared with jt6295
//   req_*       request handshake (valid/ready) and payload
//   oki_wrn     write strobe to jt6295 (active low)
//   oki_din     write data to jt6295
//   oki_dout    jt6295 status, bit n = channel n playing
//   done/err    one-clk pulses: request completed / request dropped
//   busy        high while a request is in flight or queued
module jt6295_seq #(
    parameter int AW        = 2,
    parameter int WR_CEN    = 2,
    parameter int WAIT_BUSY = 1,
    parameter int TOUT      = 4095
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cen,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_stop,
    input  logic [6:0] req_phrase,
    input  logic [1:0] req_ch,
    input  logic [3:0] req_att,
    output logic       oki_wrn,
    output logic [7:0] oki_din,
    input  logic [3:0] oki_dout,
    output logic       done,
    output logic       err,
    output logic       busy
);
    localparam int DEPTH = 2**AW;
    localparam int PW    = (WR_CEN > 1) ? $clog2(WR_CEN) : 1;

    typedef enum logic [2:0] {
        ST_IDLE, ST_CHECK, ST_W1L, ST_W1H, ST_W2L, ST_W2H, ST_DONE, ST_DROP
    } state_t;

    state_t        state, state_nxt;

    logic [14:0]   mem [DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          empty, full, push, pop;

    logic          w_stop;
    logic [6:0]    w_phrase;
    logic [1:0]    w_ch;
    logic [3:0]    w_att;

    logic [PW-1:0] pcnt;
    logic [11:0]   wcnt;
    logic          phase_end, tout_hit, ch_busy;
    logic [3:0]    ch_oh;
    logic [7:0]    byte1, byte2, din_nxt;

    // FIFO pointers carry one extra wrap bit to tell full from empty
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) &&
                       (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push      = req_valid && !full;
    assign pop       = (state == ST_IDLE) && !empty;
    assign req_ready = !full;

    assign phase_end = cen && (pcnt == PW'(WR_CEN - 1));
    assign tout_hit  = cen && (wcnt == 12'(TOUT - 1));
    assign ch_busy   = oki_dout[w_ch];
    assign ch_oh     = 4'b0001 << w_ch;
    assign byte1     = w_stop ? {1'b0, ch_oh, 3'b000} : {1'b1, w_phrase};
    assign byte2     = {ch_oh, w_att};

    always_comb begin
        state_nxt = state;
        din_nxt   = oki_din;
        case (state)
            ST_IDLE:  if (!empty) state_nxt = ST_CHECK;
            ST_CHECK: begin
                // a channel freeing on the timeout edge still wins
                if (w_stop || !ch_busy) begin
                    state_nxt = ST_W1L;
                    din_nxt   = byte1;
                end else if (WAIT_BUSY == 0) begin
                    state_nxt = ST_DROP;
                end else if (tout_hit) begin
                    state_nxt = ST_DROP;
                end
            end
            ST_W1L:   if (phase_end) state_nxt = ST_W1H;
            ST_W1H: begin
                if (phase_end) begin
                    if (w_stop) begin
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt = ST_W2L;
                        din_nxt   = byte2;
                    end
                end
            end
            ST_W2L:   if (phase_end) state_nxt = ST_W2H;
            ST_W2H:   if (phase_end) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            ST_DROP:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    assign oki_wrn = !((state == ST_W1L) || (state == ST_W2L));
    assign done    = (state == ST_DONE);
    assign err     = (state == ST_DROP);
    assign busy    = (state != ST_IDLE) || !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            oki_din  <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            w_stop   <= 1'b0;
            w_phrase <= '0;
            w_ch     <= '0;
            w_att    <= '0;
            pcnt     <= '0;
            wcnt     <= '0;
        end else begin
            state   <= state_nxt;
            oki_din <= din_nxt;
            if (push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            if (pop) begin
                rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
                {w_stop, w_phrase, w_ch, w_att} <= mem[rd_ptr[AW-1:0]];
            end
            // phase counter restarts on every state change
            if (state_nxt != state) pcnt <= '0;
            else if (cen)           pcnt <= pcnt + PW'(1);
            // wait counter only runs in CHECK, so it is zero on entry
            if (state != ST_CHECK)  wcnt <= '0;
            else if (cen)           wcnt <= wcnt + 12'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {req_stop, req_phrase, req_ch, req_att};
    end

endmodule
